// File: rtl/keccak_obi_copy_master.sv
// -----------------------------------------------------------------------------
// keccak_obi_copy_master
//
// OBI initiator for the X-HEEP external-master port. It copies a block of
// 32-bit words from memory to memory, for example a 1600-bit Keccak state
// (50 words) from SRAM into the Keccak data window, or back out again.
// Each word is read and then written, strictly in sequence, with at most one
// OBI transaction outstanding.
//
// Optional build macro:
//   KECCAK_COPY_BSWAP_EN  when defined, each word read is byte-reversed before
//                         it is written, to convert Keccak lane endianness.
//                         When undefined, words are copied unmodified.
//
// Parameters:
//   LEN_W     width of the word-count input (largest block is 2**LEN_W-1 words)
//   ADDR_INC  byte increment applied to source/destination after each word
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active high
//   start_i        single-cycle start pulse, only accepted while idle
//   src_addr_i     byte source address, latched on an accepted start
//   dst_addr_i     byte destination address, latched on an accepted start
//   len_i          number of words to copy, latched on an accepted start
//   busy_o         high while a copy is in progress, up to and including done
//   done_o         one-cycle completion pulse
//   master_req_o   OBI request  {req, we, be, addr, wdata}
//   master_resp_i  OBI response {gnt, rvalid, rdata}
// -----------------------------------------------------------------------------

package keccak_obi_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

module keccak_obi_copy_master
   import keccak_obi_pkg::*;
#(
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned ADDR_INC = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output obi_req_t         master_req_o,
   input  obi_resp_t        master_resp_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_WAIT,
      S_WR_REQ,
      S_WR_WAIT,
      S_DONE
   } state_e;

   state_e           state_q;
   state_e           state_d;

   logic [31:0]      src_q;
   logic [31:0]      dst_q;
   logic [31:0]      data_q;
   logic [LEN_W-1:0] remaining_q;
   logic [31:0]      rdata_fmt;

   // Word as it will be stored for the write-back.
`ifdef KECCAK_COPY_BSWAP_EN
   assign rdata_fmt = {master_resp_i.rdata[7:0],   master_resp_i.rdata[15:8],
                       master_resp_i.rdata[23:16], master_resp_i.rdata[31:24]};
`else
   assign rdata_fmt = master_resp_i.rdata;
`endif

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: clocked state is assigned with <= so every flop samples the values
   // from before the edge; blocking assignments here would create ordering races.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: state_d gets a default before the case so that no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               // An empty block finishes without touching the bus.
               state_d = (len_i == '0) ? S_DONE : S_RD_REQ;
            end
         end
         // An rvalid seen together with gnt in a request state is not ours.
         S_RD_REQ:  if (master_resp_i.gnt)    state_d = S_RD_WAIT;
         S_RD_WAIT: if (master_resp_i.rvalid) state_d = S_WR_REQ;
         S_WR_REQ:  if (master_resp_i.gnt)    state_d = S_WR_WAIT;
         S_WR_WAIT: begin
            if (master_resp_i.rvalid) begin
               state_d = (remaining_q == LEN_W'(1)) ? S_DONE : S_RD_REQ;
            end
         end
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath registers: addresses, word counter, data buffer
   // --------------------------------------------------------------------------
   // NOTE: the single-word data buffer is a plain register, so it is cleared
   // with the rest of the datapath; only real RAM arrays are left unreset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q       <= '0;
         dst_q       <= '0;
         data_q      <= '0;
         remaining_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  src_q       <= src_addr_i;
                  dst_q       <= dst_addr_i;
                  remaining_q <= len_i;
               end
            end
            S_RD_WAIT: begin
               if (master_resp_i.rvalid) data_q <= rdata_fmt;
            end
            S_WR_REQ: begin
               // Advance both pointers once the write is accepted; the address
               // on the bus stays stable until then. Wraps modulo 2**32.
               if (master_resp_i.gnt) begin
                  src_q <= src_q + 32'(ADDR_INC);
                  dst_q <= dst_q + 32'(ADDR_INC);
               end
            end
            S_WR_WAIT: begin
               if (master_resp_i.rvalid) remaining_q <= remaining_q - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs: decoded from the current state only, so the request stays stable
   // for as long as the state waits for gnt.
   // --------------------------------------------------------------------------
   always_comb begin
      master_req_o = '0;
      busy_o       = (state_q != S_IDLE);
      done_o       = (state_q == S_DONE);
      unique case (state_q)
         S_RD_REQ: begin
            master_req_o.req  = 1'b1;
            master_req_o.we   = 1'b0;
            master_req_o.be   = 4'hF;
            master_req_o.addr = {src_q[31:2], 2'b00};
         end
         S_WR_REQ: begin
            master_req_o.req   = 1'b1;
            master_req_o.we    = 1'b1;
            master_req_o.be    = 4'hF;
            master_req_o.addr  = {dst_q[31:2], 2'b00};
            master_req_o.wdata = data_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_keccak_obi_copy_master.sv
// -----------------------------------------------------------------------------
// Testbench for keccak_obi_copy_master.
// The bench acts as the OBI target: it grants after a random stall, returns
// rvalid a random number of cycles later and supplies random read data. Every
// granted transaction is logged and compared against the list of transactions
// a block copy must produce: for word i a read of (src+4i) and a write of
// (dst+4i), both word aligned, carrying the word read (byte-reversed when
// KECCAK_COPY_BSWAP_EN is defined).
// Cycle numbering: the cycle in which start_i is sampled is cycle 1.
// -----------------------------------------------------------------------------
module tb_keccak_obi_copy_master;
   import keccak_obi_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] src_addr_i = '0;
   logic [31:0] dst_addr_i = '0;
   logic [7:0]  len_i = '0;
   logic        busy_o;
   logic        done_o;
   obi_req_t    master_req_o;
   obi_resp_t   master_resp_i = '0;

   always #5 clk_i = ~clk_i;

   keccak_obi_copy_master #(.LEN_W(8), .ADDR_INC(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .src_addr_i   (src_addr_i),
      .dst_addr_i   (dst_addr_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .master_req_o (master_req_o),
      .master_resp_i(master_resp_i)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Job descriptor with its expected completion cycle (-1: not predicted).
   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          len;
      int          stall_max;
      int          rv_max;
      bit          noise;
      int          restart_at;
      int          exp_cyc;
   } vec_t;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obs_t;

   obs_t        obs_q[$];
   logic [31:0] rd_q[$];

   // Target behaviour knobs and state.
   int          stall_max = 0;
   int          rv_max = 1;
   bit          noise = 1'b0;
   bit          hold_gnt = 1'b0;
   bit          force_rd = 1'b0;
   logic [31:0] force_val = '0;
   int          stall_left = 0;
   int          resp_cnt = 0;
   bit          pend_rd = 1'b0;
   logic [31:0] pend_rdata = '0;
   bit          prev_pend = 1'b0;
   obi_req_t    prev_req = '0;

   function automatic logic [31:0] lane_fmt(input logic [31:0] w);
`ifdef KECCAK_COPY_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic int count_writes();
      int n = 0;
      foreach (obs_q[i]) if (obs_q[i].we) n++;
      return n;
   endfunction

   task automatic reset_target();
      stall_left = 0; resp_cnt = 0; pend_rd = 0; prev_pend = 0; hold_gnt = 0;
      master_resp_i = '0;
   endtask

   // One target cycle, called at the falling edge: observe the request and
   // drive the response sampled by the DUT at the next rising edge.
   task automatic bus_cycle();
      obi_resp_t r;
      bit        fired;
      r       = '0;
      r.rdata = $urandom;
      fired   = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            r.rvalid = 1'b1;
            fired    = 1'b1;
            if (pend_rd) r.rdata = pend_rdata;
         end
      end
      // Stray rvalid while no response is due: the DUT must ignore it.
      if (noise && resp_cnt == 0 && !fired) r.rvalid = 1'($urandom_range(0, 1));
      if (prev_pend && !rst_i) begin
         check("req_held",     32'(master_req_o.req), 32'd1);
         check("addr_stable",  master_req_o.addr,     prev_req.addr);
         check("we_stable",    32'(master_req_o.we),  32'(prev_req.we));
         check("be_stable",    32'(master_req_o.be),  32'(prev_req.be));
         check("wdata_stable", master_req_o.wdata,    prev_req.wdata);
      end
      prev_pend = 1'b0;
      if (master_req_o.req) begin
         if (stall_left == 0 && !hold_gnt) begin
            r.gnt = 1'b1;
            obs_q.push_back('{master_req_o.we, master_req_o.be, master_req_o.addr,
                              master_req_o.wdata});
            pend_rd = !master_req_o.we;
            if (pend_rd) begin
               pend_rdata = force_rd ? force_val : $urandom;
               rd_q.push_back(pend_rdata);
            end
            resp_cnt   = int'($urandom_range(1, rv_max));
            stall_left = int'($urandom_range(0, stall_max));
         end else begin
            if (stall_left > 0) stall_left--;
            prev_pend = 1'b1;
            prev_req  = master_req_o;
         end
      end
      master_resp_i = r;
   endtask

   // Reference: the transaction list a block copy has to produce.
   task automatic compare_model(input logic [31:0] src, input logic [31:0] dst, input int len);
      check("txn_count", 32'(obs_q.size()), 32'(2 * len));
      check("rd_count",  32'(rd_q.size()),  32'(len));
      for (int i = 0; i < len && 2 * i + 1 < obs_q.size() && i < rd_q.size(); i++) begin
         check("rd_we",    32'(obs_q[2*i].we),    32'd0);
         check("rd_be",    32'(obs_q[2*i].be),    32'hF);
         check("rd_addr",  obs_q[2*i].addr,       (src + 32'(4 * i)) & 32'hFFFF_FFFC);
         check("wr_we",    32'(obs_q[2*i+1].we),  32'd1);
         check("wr_be",    32'(obs_q[2*i+1].be),  32'hF);
         check("wr_addr",  obs_q[2*i+1].addr,     (dst + 32'(4 * i)) & 32'hFFFF_FFFC);
         check("wr_wdata", obs_q[2*i+1].wdata,    lane_fmt(rd_q[i]));
      end
   endtask

   task automatic run_job(input vec_t v);
      int cyc;
      int done_cyc;
      obs_q.delete();
      rd_q.delete();
      reset_target();
      stall_max  = v.stall_max;
      rv_max     = v.rv_max;
      noise      = v.noise;
      stall_left = int'($urandom_range(0, stall_max));
      @(negedge clk_i);
      start_i    = 1'b1;
      src_addr_i = v.src;
      dst_addr_i = v.dst;
      len_i      = 8'(v.len);
      bus_cycle();
      cyc      = 1;
      done_cyc = -1;
      while (cyc < 3000) begin
         @(negedge clk_i);
         cyc++;
         // Scramble the job inputs: they must have been latched at start.
         src_addr_i = $urandom;
         dst_addr_i = $urandom;
         len_i      = 8'($urandom);
         start_i    = (cyc == v.restart_at);
         bus_cycle();
         if (done_o) begin
            done_cyc = cyc;
            break;
         end
         check("busy", 32'(busy_o), 32'd1);
      end
      check("done_seen", 32'(done_o), 32'd1);
      check("busy_at_done", 32'(busy_o), 32'd1);
      if (v.exp_cyc >= 0) check("done_cycle", 32'(done_cyc), 32'(v.exp_cyc));
      @(negedge clk_i);
      start_i = 1'b0;
      bus_cycle();
      check("done_pulse_end", 32'(done_o), 32'd0);
      check("busy_end",       32'(busy_o), 32'd0);
      check("req_end",        32'(master_req_o.req), 32'd0);
      compare_model(v.src, v.dst, v.len);
   endtask

   vec_t vecs[0:7];
   vec_t rv;

   initial begin
      vecs[0] = '{32'h0000_1000, 32'h2000_0000,   3, 0, 1, 1'b0, -1,   14};
      vecs[1] = '{32'h0000_4000, 32'h0000_5000,   0, 0, 1, 1'b0, -1,    2};
      vecs[2] = '{32'h0000_0123, 32'h0000_8002,   1, 0, 1, 1'b0, -1,    6};
      vecs[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC,   4, 0, 1, 1'b0, -1,   18};
      vecs[4] = '{32'h0000_0100, 32'h0000_0200,   5, 5, 3, 1'b0, -1,   -1};
      vecs[5] = '{32'h0000_0300, 32'h0000_0400,   6, 2, 2, 1'b1, -1,   -1};
      vecs[6] = '{32'h0000_1000, 32'h0000_3000,   3, 0, 1, 1'b0,  5,   14};
      vecs[7] = '{32'h0000_8000, 32'h0000_9000, 255, 0, 1, 1'b0, -1, 1022};

      // Reset state.
      repeat (3) @(negedge clk_i);
      check("rst_req",   32'(master_req_o.req), 32'd0);
      check("rst_we",    32'(master_req_o.we),  32'd0);
      check("rst_be",    32'(master_req_o.be),  32'd0);
      check("rst_addr",  master_req_o.addr,     32'd0);
      check("rst_wdata", master_req_o.wdata,    32'd0);
      check("rst_busy",  32'(busy_o), 32'd0);
      check("rst_done",  32'(done_o), 32'd0);
      rst_i = 1'b0;

      // Directed vector table.
      for (int i = 0; i < 8; i++) run_job(vecs[i]);

      // Byte-lane handling of a known word.
      force_rd  = 1'b1;
      force_val = 32'h1122_3344;
      run_job('{32'h0000_0040, 32'h0000_0080, 1, 0, 1, 1'b0, -1, 6});
`ifdef KECCAK_COPY_BSWAP_EN
      check("bswap_wdata", (obs_q.size() > 1) ? obs_q[1].wdata : 32'hX, 32'h4433_2211);
`else
      check("plain_wdata", (obs_q.size() > 1) ? obs_q[1].wdata : 32'hX, 32'h1122_3344);
`endif
      force_rd = 1'b0;

      // Random jobs with stalls and response delays.
      for (int i = 0; i < 6; i++) begin
         rv = '{$urandom, $urandom, int'($urandom_range(1, 8)), int'($urandom_range(0, 5)),
                int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), -1, -1};
         run_job(rv);
      end

      // Reset while the write of word 2 is waiting for gnt.
      begin
         int cyc;
         obs_q.delete();
         rd_q.delete();
         reset_target();
         stall_max = 0; rv_max = 1; noise = 1'b0;
         @(negedge clk_i);
         start_i = 1'b1; src_addr_i = 32'h0000_1000; dst_addr_i = 32'h0000_2000; len_i = 8'd3;
         bus_cycle();
         cyc = 1;
         while (cyc < 50) begin
            @(negedge clk_i);
            cyc++;
            start_i = 1'b0;
            if (master_req_o.req && master_req_o.we && count_writes() == 1) begin
               hold_gnt = 1'b1;
               rst_i    = 1'b1;
               bus_cycle();
               break;
            end
            bus_cycle();
         end
         check("wr2_reached", 32'(master_req_o.we), 32'd1);
         check("wr2_cycle",   32'(cyc), 32'd8);
         @(negedge clk_i);
         check("midrst_req",  32'(master_req_o.req), 32'd0);
         check("midrst_addr", master_req_o.addr, 32'd0);
         check("midrst_busy", 32'(busy_o), 32'd0);
         check("midrst_done", 32'(done_o), 32'd0);
         rst_i = 1'b0;
         reset_target();
         for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            bus_cycle();
            check("post_rst_done", 32'(done_o), 32'd0);
            check("post_rst_req",  32'(master_req_o.req), 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
